// File: rtl/branch_ctrl_seq.sv
// branch_ctrl_seq: hardwired control-step sequencer for the conditional-branch
// class (brzr/brnz/brpl/brmi). It walks T0..T6, drives the datapath strobes as
// a Moore decode of the current step, and owns the CON (branch-taken) flop.
module branch_ctrl_seq #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [4:0]  BR_OPCODE      = 5'b10010,
  parameter int unsigned C2_LSB         = 19,
  parameter bit          SKIP_NOT_TAKEN = 1'b1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic [DATA_WIDTH-1:0] bus_value,
  output logic                  PCout,
  output logic                  MARin,
  output logic                  IncPC,
  output logic                  Zin,
  output logic                  Zlowout,
  output logic                  PCin,
  output logic                  Read,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  IRin,
  output logic                  Gra,
  output logic                  Rout,
  output logic                  CONin,
  output logic                  Yin,
  output logic                  Cout,
  output logic                  ADD,
  output logic                  Zlowin,
  output logic                  con_ff,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic [3:0]            step
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_DONE = 4'd8,
    ST_ILL  = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   con_ff_q, con_ff_d;
  // Set once T1 has been held for at least one cycle, so PCin fires only once.
  logic   t1_wait_q, t1_wait_d;
  logic   cond;
  logic   opcode_ok;
  logic   ir_unused;

  // Only the opcode and C2 fields of the IR matter to this block.
  assign ir_unused = ^ir;
  assign opcode_ok = (ir[DATA_WIDTH-1 -: 5] == BR_OPCODE);

  // Evaluate the branch condition selected by C2 against the Ra value on the bus.
  always_comb begin
    cond = 1'b0;
    case (ir[C2_LSB+1:C2_LSB])
      2'b00:   cond = (bus_value == '0);
      2'b01:   cond = (bus_value != '0);
      2'b10:   cond = ~bus_value[DATA_WIDTH-1];
      default: cond = bus_value[DATA_WIDTH-1];
    endcase
  end

  // State register; clear abandons any in-flight instruction immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-step sequencing, including the T1 memory wait and the T3 exit decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ready) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (!opcode_ok) begin
          state_d = ST_ILL;
        end else if (SKIP_NOT_TAKEN && !cond) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_T4;
        end
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = ST_T6;
      ST_T6:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ILL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // CON is captured at the end of T3 and cleared by the illegal-opcode trap.
  always_comb begin
    con_ff_d = con_ff_q;
    if (state_q == ST_T3) begin
      con_ff_d = cond;
    end else if (state_q == ST_ILL) begin
      con_ff_d = 1'b0;
    end
    t1_wait_d = (state_q == ST_T1) && !mem_ready;
  end

  // CON flop and T1-hold marker, both cleared with the sequencer.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      con_ff_q  <= 1'b0;
      t1_wait_q <= 1'b0;
    end else begin
      con_ff_q  <= con_ff_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  // Moore decode of the datapath strobes and status flags from the current step.
  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Gra     = 1'b0;
    Rout    = 1'b0;
    CONin   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    ADD     = 1'b0;
    Zlowin  = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = ~t1_wait_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        CONin = 1'b1;
      end
      ST_T4: begin
        PCout = 1'b1;
        Yin   = 1'b1;
      end
      ST_T5: begin
        Cout   = 1'b1;
        ADD    = 1'b1;
        Zlowin = 1'b1;
      end
      ST_T6: begin
        Zlowout = 1'b1;
        PCin    = con_ff_q;
      end
      ST_DONE: done    = 1'b1;
      ST_ILL:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign con_ff = con_ff_q;
  assign step   = state_q;

endmodule

// File: tb/tb_branch_ctrl_seq.sv
// tb_branch_ctrl_seq: exercises three configurations of the branch sequencer
// (32-bit with skip, 32-bit without skip, 16-bit with skip) through a vector
// table, hand-built corner sequences and random instructions, comparing each
// cycle to a trace derived from the branch-step rules.
module tb_branch_ctrl_seq;

   // Strobe positions within the 17-bit strobe field of an observation.
   localparam logic [16:0] S_PCOUT   = 17'h10000;
   localparam logic [16:0] S_MARIN   = 17'h08000;
   localparam logic [16:0] S_INCPC   = 17'h04000;
   localparam logic [16:0] S_ZIN     = 17'h02000;
   localparam logic [16:0] S_ZLOWOUT = 17'h01000;
   localparam logic [16:0] S_PCIN    = 17'h00800;
   localparam logic [16:0] S_READ    = 17'h00400;
   localparam logic [16:0] S_MDRIN   = 17'h00200;
   localparam logic [16:0] S_MDROUT  = 17'h00100;
   localparam logic [16:0] S_IRIN    = 17'h00080;
   localparam logic [16:0] S_GRA     = 17'h00040;
   localparam logic [16:0] S_ROUT    = 17'h00020;
   localparam logic [16:0] S_CONIN   = 17'h00010;
   localparam logic [16:0] S_YIN     = 17'h00008;
   localparam logic [16:0] S_COUT    = 17'h00004;
   localparam logic [16:0] S_ADD     = 17'h00002;
   localparam logic [16:0] S_ZLOWIN  = 17'h00001;

   // Debug step numbering reported on the step output.
   localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3 = 4;
   localparam int P_T4 = 5, P_T5 = 6, P_T6 = 7, P_DONE = 8, P_ILL = 9;

   typedef struct {
      int          sel;
      logic [31:0] ir;
      logic [31:0] bus;
      int          waits;
      int          exp_lat;
      bit          exp_ill;
      bit          exp_con;
   } vec_t;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic        mem_ready;
   int          sel;
   logic [31:0] ir_in;
   logic [31:0] bus_in;
   logic        start_a, start_b, start_c;
   wire  [24:0] obs_a, obs_b, obs_c;
   logic [24:0] obs;

   int          n_compared = 0;
   int          n_mismatched = 0;
   bit          model_con[3];
   logic [24:0] exp_q[$];
   int          mr_q[$];
   vec_t        vecs[12];

   always #5 clock = ~clock;

   assign start_a = start & (sel == 0);
   assign start_b = start & (sel == 1);
   assign start_c = start & (sel == 2);

   // Route the selected configuration's outputs to the common observation.
   always_comb begin
      case (sel)
         0:       obs = obs_a;
         1:       obs = obs_b;
         default: obs = obs_c;
      endcase
   end

   branch_ctrl_seq #(.DATA_WIDTH(32), .BR_OPCODE(5'b10010), .C2_LSB(19), .SKIP_NOT_TAKEN(1'b1)) dut_a (
      .clock(clock), .clear(clear), .start(start_a), .mem_ready(mem_ready),
      .ir(ir_in), .bus_value(bus_in),
      .PCout(obs_a[20]), .MARin(obs_a[19]), .IncPC(obs_a[18]), .Zin(obs_a[17]),
      .Zlowout(obs_a[16]), .PCin(obs_a[15]), .Read(obs_a[14]), .MDRin(obs_a[13]),
      .MDRout(obs_a[12]), .IRin(obs_a[11]), .Gra(obs_a[10]), .Rout(obs_a[9]),
      .CONin(obs_a[8]), .Yin(obs_a[7]), .Cout(obs_a[6]), .ADD(obs_a[5]), .Zlowin(obs_a[4]),
      .busy(obs_a[3]), .done(obs_a[2]), .illegal(obs_a[1]), .con_ff(obs_a[0]),
      .step(obs_a[24:21])
   );

   branch_ctrl_seq #(.DATA_WIDTH(32), .BR_OPCODE(5'b10010), .C2_LSB(19), .SKIP_NOT_TAKEN(1'b0)) dut_b (
      .clock(clock), .clear(clear), .start(start_b), .mem_ready(mem_ready),
      .ir(ir_in), .bus_value(bus_in),
      .PCout(obs_b[20]), .MARin(obs_b[19]), .IncPC(obs_b[18]), .Zin(obs_b[17]),
      .Zlowout(obs_b[16]), .PCin(obs_b[15]), .Read(obs_b[14]), .MDRin(obs_b[13]),
      .MDRout(obs_b[12]), .IRin(obs_b[11]), .Gra(obs_b[10]), .Rout(obs_b[9]),
      .CONin(obs_b[8]), .Yin(obs_b[7]), .Cout(obs_b[6]), .ADD(obs_b[5]), .Zlowin(obs_b[4]),
      .busy(obs_b[3]), .done(obs_b[2]), .illegal(obs_b[1]), .con_ff(obs_b[0]),
      .step(obs_b[24:21])
   );

   branch_ctrl_seq #(.DATA_WIDTH(16), .BR_OPCODE(5'b10010), .C2_LSB(9), .SKIP_NOT_TAKEN(1'b1)) dut_c (
      .clock(clock), .clear(clear), .start(start_c), .mem_ready(mem_ready),
      .ir(ir_in[15:0]), .bus_value(bus_in[15:0]),
      .PCout(obs_c[20]), .MARin(obs_c[19]), .IncPC(obs_c[18]), .Zin(obs_c[17]),
      .Zlowout(obs_c[16]), .PCin(obs_c[15]), .Read(obs_c[14]), .MDRin(obs_c[13]),
      .MDRout(obs_c[12]), .IRin(obs_c[11]), .Gra(obs_c[10]), .Rout(obs_c[9]),
      .CONin(obs_c[8]), .Yin(obs_c[7]), .Cout(obs_c[6]), .ADD(obs_c[5]), .Zlowin(obs_c[4]),
      .busy(obs_c[3]), .done(obs_c[2]), .illegal(obs_c[1]), .con_ff(obs_c[0]),
      .step(obs_c[24:21])
   );

   // Pack one expected observation: step, strobes, busy, done, illegal, CON.
   function automatic logic [24:0] mk(input int st, input logic [16:0] strb,
                                      input bit dn, input bit il, input bit con);
      return {4'(st), strb, (st != P_IDLE), dn, il, con};
   endfunction

   // Compare one value against its expectation and keep the tallies.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Build the cycle-by-cycle trace one instruction should produce, from the
   // step rules: fetch, wait, decode, optional add steps, then DONE or trap.
   // mr_q code per cycle: 0 = any mem_ready, 1 = hold low, 2 = drive high.
   task automatic buildTrace(input int s, input logic [31:0] ir_v, input logic [31:0] bus_v,
                             input int waits);
      int          width;
      bit          skip, cond, prev, msb;
      logic [31:0] v;
      logic [4:0]  opc;
      logic [1:0]  c2;
      width = (s == 2) ? 16 : 32;
      skip  = (s != 1);
      v     = (width == 16) ? {16'h0, bus_v[15:0]} : bus_v;
      opc   = (width == 16) ? ir_v[15:11] : ir_v[31:27];
      c2    = (width == 16) ? ir_v[10:9]  : ir_v[20:19];
      msb   = (width == 16) ? v[15] : v[31];
      case (c2)
         2'b00:   cond = (v == 0);
         2'b01:   cond = (v != 0);
         2'b10:   cond = !msb;
         default: cond = msb;
      endcase
      prev = model_con[s];
      exp_q.delete();
      mr_q.delete();
      exp_q.push_back(mk(P_T0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, prev));
      mr_q.push_back(0);
      for (int k = 0; k <= waits; k++) begin
         exp_q.push_back(mk(P_T1, S_ZLOWOUT | S_READ | S_MDRIN | ((k == 0) ? S_PCIN : 17'h0), 0, 0, prev));
         mr_q.push_back((k < waits) ? 1 : 2);
      end
      exp_q.push_back(mk(P_T2, S_MDROUT | S_IRIN, 0, 0, prev));
      mr_q.push_back(0);
      exp_q.push_back(mk(P_T3, S_GRA | S_ROUT | S_CONIN, 0, 0, prev));
      mr_q.push_back(0);
      if (opc != 5'b10010) begin
         exp_q.push_back(mk(P_ILL, 17'h0, 0, 1, cond));
         exp_q.push_back(mk(P_IDLE, 17'h0, 0, 0, 0));
         model_con[s] = 1'b0;
      end else begin
         if (!(skip && !cond)) begin
            exp_q.push_back(mk(P_T4, S_PCOUT | S_YIN, 0, 0, cond));
            exp_q.push_back(mk(P_T5, S_COUT | S_ADD | S_ZLOWIN, 0, 0, cond));
            exp_q.push_back(mk(P_T6, S_ZLOWOUT | (cond ? S_PCIN : 17'h0), 0, 0, cond));
            mr_q.push_back(0);
            mr_q.push_back(0);
            mr_q.push_back(0);
         end
         exp_q.push_back(mk(P_DONE, 17'h0, 1, 0, cond));
         exp_q.push_back(mk(P_IDLE, 17'h0, 0, 0, cond));
         model_con[s] = cond;
      end
      mr_q.push_back(0);
      mr_q.push_back(0);
   endtask

   // Launch one instruction on configuration s and check every cycle until it
   // is back in IDLE. Must be entered just after a falling edge while idle.
   task automatic applyStimulus(input int s, input logic [31:0] ir_v, input logic [31:0] bus_v,
                                input int waits, input bit hold, output int lat,
                                output bit ill, output bit con_after);
      buildTrace(s, ir_v, bus_v, waits);
      sel       = s;
      ir_in     = ir_v;
      bus_in    = bus_v;
      start     = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      lat       = 0;
      ill       = 1'b0;
      con_after = 1'b0;
      @(posedge clock);
      #1;
      if (!hold) start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clock);
         checkOutput($sformatf("trace s%0d c%0d", s, i), 32'(obs), 32'(exp_q[i]));
         if (lat == 0 && (obs[2] || obs[1])) lat = i + 1;
         if (obs[1]) ill = 1'b1;
         con_after = obs[0];
         case (mr_q[i])
            1:       mem_ready = 1'b0;
            2:       mem_ready = 1'b1;
            default: mem_ready = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   // Pulse clear for one cycle and forget all CON history.
   task automatic pulseClear();
      start = 1'b0;
      clear = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      model_con = '{default: 1'b0};
   endtask

   initial begin
      int          lat;
      bit          ill, con_after;
      int          s, waits;
      logic [4:0]  opc;
      logic [1:0]  c2;
      logic [31:0] ir_v, bus_v;

      vecs[0]  = '{0, 32'h09111810, 32'h80000000, 0, 5,  1'b1, 1'b0};
      vecs[1]  = '{0, 32'h90180000, 32'h80000000, 0, 8,  1'b0, 1'b1};
      vecs[2]  = '{0, 32'h90000000, 32'h00000005, 0, 5,  1'b0, 1'b0};
      vecs[3]  = '{1, 32'h90080000, 32'h00000000, 0, 8,  1'b0, 1'b0};
      vecs[4]  = '{0, 32'h90180000, 32'hFFFFFFFF, 3, 11, 1'b0, 1'b1};
      vecs[5]  = '{2, 32'h00009400, 32'h00007FFF, 0, 8,  1'b0, 1'b1};
      vecs[6]  = '{2, 32'hFFFF9400, 32'h12348000, 0, 5,  1'b0, 1'b0};
      vecs[7]  = '{1, 32'h90000000, 32'h00000000, 0, 8,  1'b0, 1'b1};
      vecs[8]  = '{0, 32'h90100000, 32'h7FFFFFFF, 0, 8,  1'b0, 1'b1};
      vecs[9]  = '{1, 32'h90180000, 32'h00000001, 2, 10, 1'b0, 1'b0};
      vecs[10] = '{1, 32'h88180000, 32'h80000000, 0, 5,  1'b1, 1'b0};
      vecs[11] = '{2, 32'h00009000, 32'hABCD0000, 0, 8,  1'b0, 1'b1};

      clear     = 1'b0;
      start     = 1'b0;
      mem_ready = 1'b1;
      ir_in     = '0;
      bus_in    = '0;
      model_con = '{default: 1'b0};
      for (int k = 0; k < 3; k++) begin
         sel = k;
         #1;
         checkOutput($sformatf("reset s%0d", k), 32'(obs), 32'h0);
      end
      @(negedge clock);
      clear = 1'b1;

      $display("[TB] vector table");
      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].sel, vecs[v].ir, vecs[v].bus, vecs[v].waits, 1'b0, lat, ill, con_after);
         checkOutput($sformatf("latency v%0d", v), 32'(lat), 32'(vecs[v].exp_lat));
         checkOutput($sformatf("illegal v%0d", v), 32'(ill), 32'(vecs[v].exp_ill));
         checkOutput($sformatf("con_ff v%0d", v), 32'(con_after), 32'(vecs[v].exp_con));
      end

      $display("[TB] clear during T5");
      sel       = 0;
      ir_in     = 32'h90180000;
      bus_in    = 32'h80000000;
      mem_ready = 1'b1;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      checkOutput("in T5 before clear", 32'(obs), 32'(mk(P_T5, S_COUT | S_ADD | S_ZLOWIN, 0, 0, 1)));
      #1;
      clear = 1'b0;
      #1;
      checkOutput("outputs after clear", 32'(obs), 32'h0);
      @(negedge clock);
      clear = 1'b1;
      model_con = '{default: 1'b0};
      applyStimulus(0, 32'h90180000, 32'h80000000, 0, 1'b0, lat, ill, con_after);
      checkOutput("latency after clear", 32'(lat), 32'd8);
      checkOutput("con_ff after clear", 32'(con_after), 32'd1);

      $display("[TB] start held high throughout");
      applyStimulus(0, 32'h90000000, 32'h00000005, 1, 1'b1, lat, ill, con_after);
      checkOutput("latency held start", 32'(lat), 32'd6);
      @(negedge clock);
      checkOutput("restart from idle", 32'(obs[24:21]), 32'(P_T0));
      pulseClear();

      $display("[TB] random instructions");
      for (int n = 0; n < 60; n++) begin
         s     = $urandom_range(0, 2);
         opc   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b10010;
         c2    = 2'($urandom_range(0, 3));
         waits = $urandom_range(0, 3);
         ir_v  = $urandom;
         if (s == 2) begin
            ir_v[15:11] = opc;
            ir_v[10:9]  = c2;
         end else begin
            ir_v[31:27] = opc;
            ir_v[20:19] = c2;
         end
         case ($urandom_range(0, 3))
            0:       bus_v = 32'h0;
            1:       bus_v = $urandom;
            2:       bus_v = 32'h00008000;
            default: bus_v = 32'h80000000;
         endcase
         applyStimulus(s, ir_v, bus_v, waits, 1'b0, lat, ill, con_after);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
